// File: rtl/axi2core_slave.sv
// AXI4 slave that serialises read/write bursts into single-beat core requests.
// One AXI transaction and one core request are in flight at any time.
module axi2core_slave #(
    parameter int AXI4_ADDRESS_WIDTH = 32,
    parameter int AXI4_ID_WIDTH      = 16,
    parameter int AXI4_USER_WIDTH    = 10
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [AXI4_ID_WIDTH-1:0]      aw_id_i,
    input  logic [AXI4_ADDRESS_WIDTH-1:0] aw_addr_i,
    input  logic [7:0]                    aw_len_i,
    input  logic [2:0]                    aw_size_i,
    input  logic [1:0]                    aw_burst_i,
    input  logic                          aw_valid_i,
    output logic                          aw_ready_o,
    input  logic [31:0]                   w_data_i,
    input  logic [3:0]                    w_strb_i,
    input  logic                          w_last_i,
    input  logic                          w_valid_i,
    output logic                          w_ready_o,
    output logic [AXI4_ID_WIDTH-1:0]      b_id_o,
    output logic [1:0]                    b_resp_o,
    output logic [AXI4_USER_WIDTH-1:0]    b_user_o,
    output logic                          b_valid_o,
    input  logic                          b_ready_i,
    input  logic [AXI4_ID_WIDTH-1:0]      ar_id_i,
    input  logic [AXI4_ADDRESS_WIDTH-1:0] ar_addr_i,
    input  logic [7:0]                    ar_len_i,
    input  logic [2:0]                    ar_size_i,
    input  logic [1:0]                    ar_burst_i,
    input  logic                          ar_valid_i,
    output logic                          ar_ready_o,
    output logic [AXI4_ID_WIDTH-1:0]      r_id_o,
    output logic [31:0]                   r_data_o,
    output logic [1:0]                    r_resp_o,
    output logic                          r_last_o,
    output logic [AXI4_USER_WIDTH-1:0]    r_user_o,
    output logic                          r_valid_o,
    input  logic                          r_ready_i,
    output logic                          data_req_o,
    input  logic                          data_gnt_i,
    input  logic                          data_rvalid_i,
    output logic [AXI4_ADDRESS_WIDTH-1:0] data_addr_o,
    output logic                          data_we_o,
    output logic [3:0]                    data_be_o,
    output logic [31:0]                   data_wdata_o,
    input  logic [31:0]                   data_rdata_i
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_REQ  = 3'd1;
    localparam logic [2:0] RD_WAIT = 3'd2;
    localparam logic [2:0] RD_RESP = 3'd3;
    localparam logic [2:0] WR_REQ  = 3'd4;
    localparam logic [2:0] WR_WAIT = 3'd5;
    localparam logic [2:0] WR_RESP = 3'd6;

    localparam logic PRIO_READ  = 1'b0;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    logic [2:0]                    state_q;
    logic                          prio_q;
    logic [AXI4_ID_WIDTH-1:0]      id_q;
    logic [AXI4_ADDRESS_WIDTH-1:0] addr_q;
    logic [7:0]                    len_q;
    logic [7:0]                    beat_q;
    logic [1:0]                    burst_q;
    logic                          err_q;
    logic                          berr_q;
    logic [31:0]                   rdata_q;

    logic                          ar_hs;
    logic                          aw_hs;
    logic                          w_hs;
    logic                          last_beat;
    logic [AXI4_ADDRESS_WIDTH-1:0] next_addr;

    // Only 32-bit beats with FIXED or INCR bursts are serviced by the core.
    function automatic logic burst_err(input logic [2:0] size, input logic [1:0] burst);
        return (size != 3'b010) || burst[1];
    endfunction

    assign ar_ready_o = ~rst_i && (state_q == IDLE) && ar_valid_i
                        && ((prio_q == PRIO_READ) || ~aw_valid_i);
    assign aw_ready_o = ~rst_i && (state_q == IDLE) && aw_valid_i
                        && ((prio_q != PRIO_READ) || ~ar_valid_i);
    assign ar_hs      = ar_valid_i && ar_ready_o;
    assign aw_hs      = aw_valid_i && aw_ready_o;
    assign w_hs       = w_valid_i && w_ready_o;
    assign last_beat  = (beat_q == len_q);
    assign next_addr  = (burst_q == BURST_INCR) ? addr_q + AXI4_ADDRESS_WIDTH'(4) : addr_q;

    assign data_req_o   = ~err_q && ((state_q == RD_REQ) || ((state_q == WR_REQ) && w_valid_i));
    assign data_we_o    = (state_q == WR_REQ);
    assign data_addr_o  = addr_q & ~AXI4_ADDRESS_WIDTH'(3);
    assign data_be_o    = (state_q == WR_REQ) ? w_strb_i : 4'h0;
    assign data_wdata_o = (state_q == WR_REQ) ? w_data_i : 32'h0;
    assign w_ready_o    = (state_q == WR_REQ) && (err_q || data_gnt_i);

    assign r_valid_o = (state_q == RD_RESP);
    assign r_id_o    = id_q;
    assign r_data_o  = rdata_q;
    assign r_resp_o  = (r_valid_o && err_q) ? RESP_SLVERR : RESP_OKAY;
    assign r_last_o  = r_valid_o && last_beat;
    assign r_user_o  = '0;

    assign b_valid_o = (state_q == WR_RESP);
    assign b_id_o    = id_q;
    assign b_resp_o  = (b_valid_o && (err_q || berr_q)) ? RESP_SLVERR : RESP_OKAY;
    assign b_user_o  = '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            prio_q  <= PRIO_READ;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            burst_q <= '0;
            err_q   <= 1'b0;
            berr_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ar_hs) begin
                        id_q    <= ar_id_i;
                        addr_q  <= ar_addr_i;
                        len_q   <= ar_len_i;
                        burst_q <= ar_burst_i;
                        beat_q  <= '0;
                        err_q   <= burst_err(ar_size_i, ar_burst_i);
                        berr_q  <= 1'b0;
                        rdata_q <= '0;
                        prio_q  <= ~prio_q;
                        state_q <= RD_REQ;
                    end else if (aw_hs) begin
                        id_q    <= aw_id_i;
                        addr_q  <= aw_addr_i;
                        len_q   <= aw_len_i;
                        burst_q <= aw_burst_i;
                        beat_q  <= '0;
                        err_q   <= burst_err(aw_size_i, aw_burst_i);
                        berr_q  <= 1'b0;
                        prio_q  <= ~prio_q;
                        state_q <= WR_REQ;
                    end
                end
                RD_REQ: begin
                    if (err_q) begin
                        rdata_q <= '0;
                        state_q <= RD_RESP;
                    end else if (data_gnt_i) begin
                        state_q <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (data_rvalid_i) begin
                        rdata_q <= data_rdata_i;
                        state_q <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (r_ready_i) begin
                        if (last_beat) begin
                            state_q <= IDLE;
                        end else begin
                            beat_q  <= beat_q + 8'd1;
                            addr_q  <= next_addr;
                            state_q <= RD_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    if (w_hs) begin
                        // The beat count terminates the burst; a misplaced w_last only taints B.
                        if (w_last_i != last_beat) berr_q <= 1'b1;
                        if (!err_q) begin
                            state_q <= WR_WAIT;
                        end else if (last_beat) begin
                            state_q <= WR_RESP;
                        end else begin
                            beat_q <= beat_q + 8'd1;
                            addr_q <= next_addr;
                        end
                    end
                end
                WR_WAIT: begin
                    if (data_rvalid_i) begin
                        if (last_beat) begin
                            state_q <= WR_RESP;
                        end else begin
                            beat_q  <= beat_q + 8'd1;
                            addr_q  <= next_addr;
                            state_q <= WR_REQ;
                        end
                    end
                end
                WR_RESP: begin
                    if (b_ready_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi2core_slave.sv
// Bench for axi2core_slave: directed vector table, arbitration/reset sequences,
// and randomised bursts checked against a word-array memory model.
module tb_axi2core_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] aw_id_i, ar_id_i, b_id_o, r_id_o;
    logic [31:0] aw_addr_i, ar_addr_i, data_addr_o;
    logic [7:0]  aw_len_i, ar_len_i;
    logic [2:0]  aw_size_i, ar_size_i;
    logic [1:0]  aw_burst_i, ar_burst_i, b_resp_o, r_resp_o;
    logic        aw_valid_i, aw_ready_o, ar_valid_i, ar_ready_o;
    logic [31:0] w_data_i, r_data_o, data_wdata_o, data_rdata_i;
    logic [3:0]  w_strb_i, data_be_o;
    logic        w_last_i, w_valid_i, w_ready_o;
    logic [9:0]  b_user_o, r_user_o;
    logic        b_valid_o, b_ready_i, r_last_o, r_valid_o, r_ready_i;
    logic        data_req_o, data_gnt_i, data_rvalid_i, data_we_o;

    always #5 clk = ~clk;

    axi2core_slave #(.AXI4_ADDRESS_WIDTH(32), .AXI4_ID_WIDTH(16), .AXI4_USER_WIDTH(10)) dut (
        .clk_i(clk), .rst_i(rst),
        .aw_id_i(aw_id_i), .aw_addr_i(aw_addr_i), .aw_len_i(aw_len_i), .aw_size_i(aw_size_i),
        .aw_burst_i(aw_burst_i), .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o),
        .w_data_i(w_data_i), .w_strb_i(w_strb_i), .w_last_i(w_last_i), .w_valid_i(w_valid_i),
        .w_ready_o(w_ready_o),
        .b_id_o(b_id_o), .b_resp_o(b_resp_o), .b_user_o(b_user_o), .b_valid_o(b_valid_o),
        .b_ready_i(b_ready_i),
        .ar_id_i(ar_id_i), .ar_addr_i(ar_addr_i), .ar_len_i(ar_len_i), .ar_size_i(ar_size_i),
        .ar_burst_i(ar_burst_i), .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o),
        .r_id_o(r_id_o), .r_data_o(r_data_o), .r_resp_o(r_resp_o), .r_last_o(r_last_o),
        .r_user_o(r_user_o), .r_valid_o(r_valid_o), .r_ready_i(r_ready_i),
        .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
        .data_addr_o(data_addr_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
        .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i)
    );

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } core_t;

    typedef struct {
        bit          we;
        logic [15:0] id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          stall;
        int          bad;
        logic [1:0]  exp_resp;
        int          exp_nreq;
        int          exp_lat;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    core_t       rd_log[$];
    core_t       wr_log[$];
    logic [31:0] core_mem [0:255];
    logic [31:0] ref_mem  [0:255];
    int          rv_delay = 0;
    bit          gnt_rand = 1'b0;
    int          pend_cnt = -1;
    logic [31:0] p_addr;
    bit          p_we;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int widx(input logic [31:0] a);
        return int'(a[9:2]);
    endfunction

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Core-side memory: grants requests, answers with rvalid rv_delay cycles after the grant.
    initial begin
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0;
        forever begin
            @(negedge clk);
            data_rvalid_i = 1'b0;
            data_rdata_i  = $urandom;
            if (pend_cnt == 0) begin
                data_rvalid_i = 1'b1;
                data_rdata_i  = p_we ? 32'h0 : core_mem[widx(p_addr)];
                pend_cnt = -1;
            end else if (pend_cnt > 0) begin
                pend_cnt--;
            end
            #1;
            data_gnt_i = data_req_o && (!gnt_rand || ($urandom_range(0, 2) != 0));
            #1;
            if (data_req_o && data_gnt_i) begin
                if (data_we_o) begin
                    for (int b = 0; b < 4; b++)
                        if (data_be_o[b]) core_mem[widx(data_addr_o)][8*b +: 8] = data_wdata_o[8*b +: 8];
                    wr_log.push_back('{1'b1, data_addr_o, data_wdata_o, data_be_o});
                end else begin
                    rd_log.push_back('{1'b0, data_addr_o, 32'h0, 4'h0});
                end
                pend_cnt = rv_delay;
                p_addr   = data_addr_o;
                p_we     = data_we_o;
            end
        end
    end

    task automatic do_read(input logic [15:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int stall,
                           output logic [1:0] last_resp, output int nreq, output int hs_cyc,
                           output int lat);
        bit          err;
        int          t;
        logic [31:0] ea;
        logic [31:0] held;
        err = (size != 3'd2) || burst[1];
        last_resp = 2'bxx; nreq = -1; hs_cyc = -1; lat = -1;
        rd_log.delete();
        @(negedge clk);
        ar_id_i = id; ar_addr_i = addr; ar_len_i = len; ar_size_i = size; ar_burst_i = burst;
        ar_valid_i = 1'b1;
        t = 0;
        #2;
        while (!ar_ready_o && t < 200) begin @(negedge clk); #2; t++; end
        chk("ar_accept", ar_ready_o, 1);
        hs_cyc = cyc;
        @(negedge clk);
        ar_valid_i = 1'b0;
        if (t >= 200) return;
        for (int beat = 0; beat <= int'(len); beat++) begin
            t = 0;
            #2;
            while (!r_valid_o && t < 300) begin @(negedge clk); #2; t++; end
            if (!r_valid_o) begin chk("r_valid_timeout", 0, 1); return; end
            if (lat < 0) lat = cyc - hs_cyc;
            held = r_data_o;
            for (int s = 0; s < stall; s++) begin
                @(negedge clk); #2;
                chk("r_hold", {r_valid_o, r_data_o, r_last_o}, {1'b1, held, beat == int'(len)});
            end
            @(negedge clk);
            r_ready_i = 1'b1;
            #2;
            ea = ((burst == 2'b01) ? addr + 32'(4 * beat) : addr) & ~32'h3;
            chk("r_data", r_data_o, err ? 32'h0 : ref_mem[widx(ea)]);
            chk("r_resp", r_resp_o, err ? 2'b10 : 2'b00);
            chk("r_last", r_last_o, beat == int'(len));
            chk("r_id", r_id_o, id);
            last_resp = r_resp_o;
            @(negedge clk);
            r_ready_i = 1'b0;
        end
        nreq = rd_log.size();
        if (!err) begin
            for (int i = 0; i <= int'(len) && i < rd_log.size(); i++) begin
                ea = ((burst == 2'b01) ? addr + 32'(4 * i) : addr) & ~32'h3;
                chk("core_rd_addr", rd_log[i].addr, ea);
            end
        end
    endtask

    task automatic do_write(input logic [15:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int bad,
                            output logic [1:0] bresp, output int nreq, output int hs_cyc);
        bit          err;
        bit          acc;
        int          t;
        int          i;
        logic [31:0] ea;
        logic [31:0] wd [0:255];
        logic [3:0]  wb [0:255];
        err = (size != 3'd2) || burst[1];
        bresp = 2'bxx; nreq = -1; hs_cyc = -1;
        for (int k = 0; k <= int'(len); k++) begin
            wd[k] = $urandom;
            wb[k] = 4'($urandom_range(1, 15));
        end
        wr_log.delete();
        @(negedge clk);
        aw_id_i = id; aw_addr_i = addr; aw_len_i = len; aw_size_i = size; aw_burst_i = burst;
        aw_valid_i = 1'b1;
        t = 0;
        #2;
        while (!aw_ready_o && t < 200) begin @(negedge clk); #2; t++; end
        chk("aw_accept", aw_ready_o, 1);
        hs_cyc = cyc;
        @(negedge clk);
        aw_valid_i = 1'b0;
        if (t >= 200) return;
        i = 0; t = 0; w_valid_i = 1'b0;
        while (i <= int'(len) && t < 3000) begin
            if (!w_valid_i) w_valid_i = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            w_data_i = wd[i];
            w_strb_i = wb[i];
            w_last_i = (i == int'(len)) != (i == bad);
            #2;
            acc = w_valid_i && w_ready_o;
            if (acc) i++;
            @(negedge clk);
            t++;
            if (acc) w_valid_i = 1'b0;
        end
        w_valid_i = 1'b0; w_last_i = 1'b0;
        chk("w_beats", i, int'(len) + 1);
        t = 0;
        b_ready_i = 1'($urandom_range(0, 1));
        #2;
        while (!(b_valid_o && b_ready_i) && t < 300) begin
            @(negedge clk); b_ready_i = 1'($urandom_range(0, 1)); #2; t++;
        end
        chk("b_handshake", b_valid_o && b_ready_i, 1);
        chk("b_id", b_id_o, id);
        chk("b_resp", b_resp_o, (err || (bad >= 0 && bad <= int'(len))) ? 2'b10 : 2'b00);
        bresp = b_resp_o;
        @(negedge clk);
        b_ready_i = 1'b0;
        nreq = wr_log.size();
        if (!err) begin
            for (int k = 0; k <= int'(len); k++) begin
                ea = ((burst == 2'b01) ? addr + 32'(4 * k) : addr) & ~32'h3;
                for (int b = 0; b < 4; b++)
                    if (wb[k][b]) ref_mem[widx(ea)][8*b +: 8] = wd[k][8*b +: 8];
                if (k < wr_log.size()) begin
                    chk("core_wr_addr", wr_log[k].addr, ea);
                    chk("core_wr_data", {wr_log[k].be, wr_log[k].data}, {wb[k], wd[k]});
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt [8];
        logic [1:0]  resp, resp2;
        int          nreq, nreq2, hs_r, hs_w, lat, exp_nreq;
        logic [31:0] v;

        vt[0] = '{0, 16'h1234, 32'h100, 8'd0, 3'd2, 2'b01, 0, -1, 2'b00, 1, 3};
        vt[1] = '{1, 16'h0A5A, 32'h200, 8'd3, 3'd2, 2'b01, 0, -1, 2'b00, 4, -1};
        vt[2] = '{0, 16'h0077, 32'h200, 8'd3, 3'd2, 2'b01, 1, -1, 2'b00, 4, -1};
        vt[3] = '{0, 16'h0033, 32'h204, 8'd2, 3'd2, 2'b00, 3, -1, 2'b00, 3, -1};
        vt[4] = '{0, 16'h00E1, 32'h040, 8'd1, 3'd3, 2'b01, 0, -1, 2'b10, 0, -1};
        vt[5] = '{1, 16'h00E2, 32'h080, 8'd2, 3'd2, 2'b10, 0, -1, 2'b10, 0, -1};
        vt[6] = '{1, 16'h00B0, 32'h300, 8'd2, 3'd2, 2'b01, 0,  1, 2'b10, 3, -1};
        vt[7] = '{0, 16'h00B1, 32'h300, 8'd2, 3'd2, 2'b01, 0, -1, 2'b00, 3, -1};

        for (int k = 0; k < 256; k++) begin
            v = $urandom;
            core_mem[k] = v;
            ref_mem[k]  = v;
        end
        core_mem[widx(32'h100)] = 32'hDEADBEEF;
        ref_mem[widx(32'h100)]  = 32'hDEADBEEF;

        aw_id_i = '0; aw_addr_i = '0; aw_len_i = '0; aw_size_i = 3'd2; aw_burst_i = 2'b01;
        ar_id_i = '0; ar_addr_i = '0; ar_len_i = '0; ar_size_i = 3'd2; ar_burst_i = 2'b01;
        w_data_i = '0; w_strb_i = '0; w_last_i = 1'b0; w_valid_i = 1'b0;
        b_ready_i = 1'b0; r_ready_i = 1'b0;
        rst = 1'b1;
        ar_valid_i = 1'b1; aw_valid_i = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_ar_ready", ar_ready_o, 0);
        chk("rst_aw_ready", aw_ready_o, 0);
        chk("rst_r_valid", r_valid_o, 0);
        chk("rst_b_valid", b_valid_o, 0);
        chk("rst_data_req", data_req_o, 0);
        chk("rst_w_ready", w_ready_o, 0);
        chk("rst_r_data", r_data_o, 0);
        chk("rst_r_last", r_last_o, 0);
        chk("rst_b_resp", b_resp_o, 0);
        chk("rst_data_addr", data_addr_o, 0);
        chk("rst_data_be", {data_be_o, data_wdata_o}, 0);
        @(negedge clk);
        ar_valid_i = 1'b0; aw_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Simultaneous AR/AW: read wins twice from reset, then a lone read hands priority to write.
        for (int round = 0; round < 3; round++) begin
            if (round == 2) begin
                do_read(16'h0005, 32'h010, 8'd0, 3'd2, 2'b01, 0, resp, nreq, hs_r, lat);
                chk("arb_lone_read", resp, 2'b00);
            end
            fork
                do_read(16'h0001, 32'h040 + 32'(round * 16), 8'd1, 3'd2, 2'b01, 0, resp, nreq, hs_r, lat);
                do_write(16'h0002, 32'h080 + 32'(round * 16), 8'd1, 3'd2, 2'b01, -1, resp2, nreq2, hs_w);
            join
            chk($sformatf("arb_order_round%0d", round), hs_r < hs_w, round < 2);
            chk("arb_nreq", {16'(nreq), 16'(nreq2)}, {16'd2, 16'd2});
        end

        for (int k = 0; k < 8; k++) begin
            if (vt[k].we)
                do_write(vt[k].id, vt[k].addr, vt[k].len, vt[k].size, vt[k].burst, vt[k].bad,
                         resp, nreq, hs_w);
            else
                do_read(vt[k].id, vt[k].addr, vt[k].len, vt[k].size, vt[k].burst, vt[k].stall,
                        resp, nreq, hs_r, lat);
            chk($sformatf("vec%0d_resp", k), resp, vt[k].exp_resp);
            chk($sformatf("vec%0d_nreq", k), nreq, vt[k].exp_nreq);
            if (vt[k].exp_lat >= 0) chk($sformatf("vec%0d_latency", k), lat, vt[k].exp_lat);
        end

        // Reset while waiting on the core; the late rvalid must be ignored.
        rv_delay = 2;
        @(negedge clk);
        ar_id_i = 16'h0DD0; ar_addr_i = 32'h120; ar_len_i = 8'd0; ar_size_i = 3'd2; ar_burst_i = 2'b01;
        ar_valid_i = 1'b1;
        #2;
        chk("rstmid_ar_ready", ar_ready_o, 1);
        @(negedge clk);
        ar_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #2;
        chk("rstmid_r_valid_in_rst", r_valid_o, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #2;
            chk("rstmid_r_valid_after", {r_valid_o, data_req_o}, 2'b00);
        end
        rv_delay = 0;
        @(negedge clk);
        ar_id_i = 16'h0DD1; ar_addr_i = 32'h124; ar_valid_i = 1'b1;
        #2;
        chk("rstmid_idle", ar_ready_o, 1);
        #1;
        ar_valid_i = 1'b0;
        do_read(16'h0DD1, 32'h124, 8'd0, 3'd2, 2'b01, 0, resp, nreq, hs_r, lat);
        chk("rstmid_next_read", {30'(nreq), resp}, {30'd1, 2'b00});

        gnt_rand = 1'b1;
        for (int k = 0; k < 40; k++) begin
            bit          we;
            int          r, bad, stall;
            logic [7:0]  len;
            logic [2:0]  size;
            logic [1:0]  burst;
            logic [31:0] addr;
            we    = 1'($urandom_range(0, 1));
            len   = 8'($urandom_range(0, 7));
            addr  = 32'($urandom_range(0, 1023));
            size  = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'd2;
            r     = $urandom_range(0, 9);
            burst = (r < 4) ? 2'b01 : (r < 8) ? 2'b00 : (r == 8) ? 2'b10 : 2'b11;
            stall = $urandom_range(0, 2);
            bad   = ($urandom_range(0, 5) == 0) ? $urandom_range(0, int'(len)) : -1;
            rv_delay = $urandom_range(0, 2);
            exp_nreq = ((size != 3'd2) || burst[1]) ? 0 : int'(len) + 1;
            if (we) do_write(16'($urandom), addr, len, size, burst, bad, resp, nreq, hs_w);
            else    do_read(16'($urandom), addr, len, size, burst, stall, resp, nreq, hs_r, lat);
            chk("rand_nreq", nreq, exp_nreq);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
